// File: rtl/st7789_fill_if.sv
// Byte pull channel between the ST7789 stream generator and the SPI master.
// The source presents out/out_dc while empty=0; the sink pops with get.
interface st7789_fill_if;
  logic [7:0] out;
  logic       out_dc;
  logic       empty;
  logic       get;

  modport master (output out, output out_dc, output empty, input get);
  modport slave  (input out, input out_dc, input empty, output get);
endinterface

// File: rtl/st7789_fill.sv
// ST7789 rectangle fill: CASET/RASET/RAMWR then one RGB565 pair per pixel; first byte visible the
// cycle after start, 1 byte/clock under sustained get; get=0 holds the current byte indefinitely.
module st7789_fill #(
  parameter int CW = 9
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  input  logic [15:0]   color,
  st7789_fill_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CASET = 3'd1,
    RASET = 3'd2,
    RAMWR = 3'd3,
    PIXEL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [2:0]    idx, idx_d;
  logic [CW-1:0] col, col_d;
  logic [CW-1:0] row, row_d;
  logic          half, half_d;
  logic [CW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [15:0]   color_q;
  logic          error_q;
  logic          bad_rect;
  logic          pop;

  assign bad_rect = (x1 < x0) || (y1 < y0);
  assign pop      = bus.get && !bus.empty;

  // Argument byte k (1..4) of a command: first word hi/lo, then second word hi/lo.
  function automatic logic [7:0] arg_byte(input logic [2:0] k, input logic [CW-1:0] a,
                                          input logic [CW-1:0] b);
    logic [15:0] aw;
    logic [15:0] bw;
    aw = 16'(a);
    bw = 16'(b);
    case (k)
      3'd1:    arg_byte = aw[15:8];
      3'd2:    arg_byte = aw[7:0];
      3'd3:    arg_byte = bw[15:8];
      default: arg_byte = bw[7:0];
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      col     <= '0;
      row     <= '0;
      half    <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      error_q <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      col     <= col_d;
      row     <= row_d;
      half    <= half_d;
      error_q <= (state == IDLE) && start && bad_rect;
      if (state == IDLE && start) begin
        x0_q    <= x0;
        y0_q    <= y0;
        x1_q    <= x1;
        y1_q    <= y1;
        color_q <= color;
      end
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    col_d   = col;
    row_d   = row;
    half_d  = half;
    case (state)
      IDLE: begin
        idx_d = '0;
        if (start && !bad_rect) state_d = CASET;
      end
      CASET, RASET: begin
        if (pop) begin
          if (idx == 3'd4) begin
            idx_d   = '0;
            state_d = (state == CASET) ? RASET : RAMWR;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      RAMWR: begin
        if (pop) begin
          state_d = PIXEL;
          col_d   = x0_q;
          row_d   = y0_q;
          half_d  = 1'b0;
        end
      end
      PIXEL: begin
        // Compare against the bound before incrementing so x1/y1 at 2^CW-1 never wrap.
        if (pop) begin
          half_d = ~half;
          if (half) begin
            if (col == x1_q) begin
              col_d = x0_q;
              if (row == y1_q) state_d = DONE;
              else             row_d   = row + 1'b1;
            end else begin
              col_d = col + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out    = 8'h00;
    bus.out_dc = 1'b0;
    case (state)
      CASET: begin
        bus.out    = (idx == 3'd0) ? 8'h2A : arg_byte(idx, x0_q, x1_q);
        bus.out_dc = (idx != 3'd0);
      end
      RASET: begin
        bus.out    = (idx == 3'd0) ? 8'h2B : arg_byte(idx, y0_q, y1_q);
        bus.out_dc = (idx != 3'd0);
      end
      RAMWR:   bus.out = 8'h2C;
      PIXEL: begin
        bus.out    = half ? color_q[7:0] : color_q[15:8];
        bus.out_dc = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state == CASET) || (state == RASET) || (state == RAMWR) || (state == PIXEL);
  assign bus.empty = !busy;
  assign done      = (state == DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_st7789_fill.sv
// Bench for st7789_fill: random get patterns and rectangles checked against a byte-list model.
module tb_st7789_fill;
  localparam int CW     = 9;
  localparam int BUDGET = 20000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [15:0]   color = '0;
  logic          busy, done, error;

  st7789_fill_if bus ();

  st7789_fill #(.CW(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1),
    .y1      (y1),
    .color   (color),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         s_cycles, s_stable_err, s_busy_err;
  bit         s_timeout, s_done_empty, s_done_busy, s_done_twice;
  logic [8:0] s_first;
  logic       s_first_empty;

  // Expected stream built straight from the command list: {dc, byte}.
  task automatic build_model(input logic [CW-1:0] a0, b0, a1, b1, input logic [15:0] c);
    logic [15:0] w0, w1, h0, h1;
    w0 = 16'(a0); w1 = 16'(a1); h0 = 16'(b0); h1 = 16'(b1);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, w0[15:8]}); exp_q.push_back({1'b1, w0[7:0]});
    exp_q.push_back({1'b1, w1[15:8]}); exp_q.push_back({1'b1, w1[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, h0[15:8]}); exp_q.push_back({1'b1, h0[7:0]});
    exp_q.push_back({1'b1, h1[15:8]}); exp_q.push_back({1'b1, h1[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    for (int r = int'(b0); r <= int'(b1); r++)
      for (int cl = int'(a0); cl <= int'(a1); cl++) begin
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
  endtask

  function automatic int seq_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Starts a fill and pops bytes with the given get probability until done (bounded).
  task automatic drive_stream(input logic [CW-1:0] a0, b0, a1, b1, input logic [15:0] c,
                              input int get_pct, input bit poke);
    bit         g, prev_hold;
    logic [8:0] prev_b;
    got_q.delete();
    s_cycles = 0; s_stable_err = 0; s_busy_err = 0;
    s_timeout = 1'b1; s_done_empty = 1'b0; s_done_busy = 1'b1;
    prev_hold = 1'b0; prev_b = '0;
    x0 = a0; y0 = b0; x1 = a1; y1 = b1; color = c; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    s_first = {bus.out_dc, bus.out};
    s_first_empty = bus.empty;
    for (int k = 0; k < BUDGET; k++) begin
      if (done) begin
        s_timeout = 1'b0; s_done_empty = bus.empty; s_done_busy = busy;
        break;
      end
      if (!busy || bus.empty) s_busy_err++;
      if (prev_hold && ({bus.out_dc, bus.out} !== prev_b)) s_stable_err++;
      g = ($urandom_range(99) < get_pct);
      bus.get = g;
      if (g) got_q.push_back({bus.out_dc, bus.out});
      prev_hold = !g;
      prev_b = {bus.out_dc, bus.out};
      if (poke && k == 3) begin
        start = 1'b1; x0 = 0; x1 = 7; y0 = 0; y1 = 7; color = 16'h1234;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      s_cycles++;
    end
    bus.get = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    s_done_twice = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.get = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_checks++;
    if ({bus.empty, busy, done, error} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got e/b/d/err=%b want 1000", {bus.empty, busy, done, error});
    end
    n_checks++;
    if ({bus.out_dc, bus.out} !== 9'h000) begin
      n_fail++; $display("FAIL reset_out got %h want 000", {bus.out_dc, bus.out});
    end
  endtask

  task automatic test_one_pixel();
    int d;
    build_model(0, 0, 0, 0, 16'hF800);
    drive_stream(0, 0, 0, 0, 16'hF800, 100, 1'b0);
    d = seq_diff();
    n_checks++;
    if (s_first_empty !== 1'b0 || s_first !== 9'h02A) begin
      n_fail++; $display("FAIL one_first got empty=%b byte=%h want 0/02A", s_first_empty, s_first);
    end
    n_checks++;
    if (got_q.size() != 13) begin
      n_fail++; $display("FAIL one_count got %0d want 13", got_q.size());
    end
    n_checks++;
    if (d != -1) begin
      n_fail++; $display("FAIL one_seq idx %0d got %h want %h", d,
                         (d < got_q.size()) ? got_q[d] : 9'h1FF, (d < exp_q.size()) ? exp_q[d] : 9'h1FF);
    end
    n_checks++;
    if (s_timeout || s_cycles != 13) begin
      n_fail++; $display("FAIL one_done_timing got cycles=%0d timeout=%b want 13/0", s_cycles, s_timeout);
    end
    n_checks++;
    if (!s_done_empty || s_done_busy || s_done_twice) begin
      n_fail++; $display("FAIL one_done_flags got empty=%b busy=%b again=%b want 1/0/0",
                         s_done_empty, s_done_busy, s_done_twice);
    end
  endtask

  task automatic test_small_rect();
    int d;
    build_model(1, 5, 2, 7, 16'h07E0);
    drive_stream(1, 5, 2, 7, 16'h07E0, 100, 1'b0);
    d = seq_diff();
    n_checks++;
    if (got_q.size() != 23) begin
      n_fail++; $display("FAIL small_count got %0d want 23", got_q.size());
    end
    n_checks++;
    if (d != -1) begin
      n_fail++; $display("FAIL small_seq idx %0d got %h want %h", d,
                         (d < got_q.size()) ? got_q[d] : 9'h1FF, (d < exp_q.size()) ? exp_q[d] : 9'h1FF);
    end
    n_checks++;
    if (s_busy_err != 0 || s_timeout) begin
      n_fail++; $display("FAIL small_busy got busy_drops=%0d timeout=%b want 0/0", s_busy_err, s_timeout);
    end
  endtask

  task automatic test_bounds();
    int d;
    build_model(0, 319, 319, 319, 16'hA5C3);
    drive_stream(0, 319, 319, 319, 16'hA5C3, 100, 1'b0);
    d = seq_diff();
    n_checks++;
    if (got_q.size() != 11 + 640) begin
      n_fail++; $display("FAIL bounds_count got %0d want 651", got_q.size());
    end
    n_checks++;
    if (got_q.size() >= 5 && {got_q[3][7:0], got_q[4][7:0]} !== 16'h013F) begin
      n_fail++; $display("FAIL bounds_x1 got %h%h want 013F", got_q[3][7:0], got_q[4][7:0]);
    end
    n_checks++;
    if (d != -1) begin
      n_fail++; $display("FAIL bounds_seq idx %0d got %h want %h", d,
                         (d < got_q.size()) ? got_q[d] : 9'h1FF, (d < exp_q.size()) ? exp_q[d] : 9'h1FF);
    end
  endtask

  task automatic test_random_get();
    int d;
    int bad;
    bad = 0;
    bus.get = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      if (!bus.empty || busy || done) bad++;
    end
    bus.get = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL idle_get got %0d disturbed cycles want 0", bad);
    end
    build_model(1, 5, 2, 7, 16'h07E0);
    drive_stream(1, 5, 2, 7, 16'h07E0, 40, 1'b0);
    d = seq_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++; $display("FAIL rget_seq idx %0d got %h want %h size %0d/%0d", d,
                         (d < got_q.size()) ? got_q[d] : 9'h1FF, (d < exp_q.size()) ? exp_q[d] : 9'h1FF,
                         got_q.size(), exp_q.size());
    end
    n_checks++;
    if (s_stable_err != 0 || s_busy_err != 0 || s_timeout) begin
      n_fail++; $display("FAIL rget_hold got unstable=%0d busy_drops=%0d timeout=%b want 0/0/0",
                         s_stable_err, s_busy_err, s_timeout);
    end
    build_model(0, 319, 319, 319, 16'h5A3C);
    drive_stream(0, 319, 319, 319, 16'h5A3C, 55, 1'b0);
    d = seq_diff();
    n_checks++;
    if (d != -1 || s_stable_err != 0) begin
      n_fail++; $display("FAIL rget_bounds idx %0d unstable=%0d size %0d/%0d", d, s_stable_err,
                         got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_error();
    int pulses;
    int bad;
    for (int t = 0; t < 2; t++) begin
      pulses = 0; bad = 0;
      if (t == 0) begin x0 = 4; x1 = 3; y0 = 0; y1 = 0; end
      else        begin x0 = 0; x1 = 0; y0 = 9; y1 = 8; end
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (error) pulses++;
        if (!bus.empty || busy || done) bad++;
        @(posedge clock); #1;
      end
      n_checks++;
      if (pulses != 1 || bad != 0) begin
        n_fail++; $display("FAIL error_case%0d got pulses=%0d active=%0d want 1/0", t, pulses, bad);
      end
    end
  endtask

  task automatic test_start_ignored();
    int d;
    build_model(2, 3, 4, 4, 16'hBEEF);
    drive_stream(2, 3, 4, 4, 16'hBEEF, 70, 1'b1);
    d = seq_diff();
    n_checks++;
    if (d != -1 || s_timeout || s_done_twice) begin
      n_fail++; $display("FAIL busy_start idx %0d timeout=%b again=%b size %0d/%0d", d, s_timeout,
                         s_done_twice, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int d;
    int dones;
    x0 = 3; x1 = 9; y0 = 1; y1 = 4; color = 16'hCAFE; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; bus.get = 1'b1;
    repeat (7) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1; bus.get = 1'b0;
    n_checks++;
    if ({bus.empty, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL midrst_flags got e/b/d=%b want 100", {bus.empty, busy, done});
    end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || !bus.empty) dones++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL midrst_quiet got %0d active cycles want 0", dones);
    end
    build_model(1, 1, 2, 2, 16'h0F0F);
    drive_stream(1, 1, 2, 2, 16'h0F0F, 100, 1'b0);
    d = seq_diff();
    n_checks++;
    if (s_first !== 9'h02A || d != -1) begin
      n_fail++; $display("FAIL midrst_fresh got first=%h diff_idx=%0d want 02A/-1", s_first, d);
    end
  endtask

  task automatic test_random_rects();
    logic [CW-1:0] a0, b0, a1, b1;
    logic [15:0]   c;
    int d;
    for (int t = 0; t < 6; t++) begin
      a0 = CW'($urandom_range(500)); b0 = CW'($urandom_range(500));
      a1 = a0 + CW'($urandom_range(5)); b1 = b0 + CW'($urandom_range(4));
      c  = 16'($urandom);
      build_model(a0, b0, a1, b1, c);
      drive_stream(a0, b0, a1, b1, c, $urandom_range(30, 100), 1'b0);
      d = seq_diff();
      n_checks++;
      if (d != -1 || s_stable_err != 0 || s_timeout) begin
        n_fail++; $display("FAIL rand_rect%0d (%0d,%0d)-(%0d,%0d) idx %0d unstable=%0d timeout=%b",
                           t, a0, b0, a1, b1, d, s_stable_err, s_timeout);
      end
    end
  endtask

  initial begin
    bus.get = 1'b0;
    test_reset();
    test_one_pixel();
    test_small_rect();
    test_bounds();
    test_random_get();
    test_error();
    test_start_ignored();
    test_mid_reset();
    test_random_rects();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
